// File: rtl/pipe_stage_skid_pkg.sv
// rtl/pipe_stage_skid_pkg.sv - shared constants for pipeline boundary stages
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR_ENC  = 32'h0000_0013;
    localparam int          DATA_W_DEFAULT = 96;
    localparam int          CTRL_W_DEFAULT = 12;

    // Bit offsets of the control bundle fields, MSB first
    localparam int CTRL_PC_SEL      = 11;
    localparam int CTRL_RB_WR       = 10;
    localparam int CTRL_RB1_SEL     = 9;
    localparam int CTRL_RB2_SEL     = 8;
    localparam int CTRL_BR_SEL      = 7;
    localparam int CTRL_ALU_CTL_MSB = 6;
    localparam int CTRL_ALU_CTL_LSB = 3;
    localparam int CTRL_DM_WR       = 2;
    localparam int CTRL_DM_SEL      = 1;
    localparam int CTRL_DM_PC_SEL   = 0;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// rtl/pipe_stage_skid_if.sv - valid/ready stream carrying one pipeline entry
interface pipe_stage_skid_if
    import pipe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int CTRL_W = CTRL_W_DEFAULT
);
    logic              valid;
    logic              ready;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_nxt;
    logic [XLEN-1:0]   instr;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;

    modport master (output valid, pc, pc_nxt, instr, data, ctrl, input ready);
    modport slave  (input valid, pc, pc_nxt, instr, data, ctrl, output ready);
endinterface

// File: rtl/pipe_stage_skid_sat_counter.sv
// rtl/pipe_stage_skid_sat_counter.sv - saturating event counter
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - stage boundary register with skid buffer, flush and event counters
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              DATA_W    = DATA_W_DEFAULT,
    parameter int              CTRL_W    = CTRL_W_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(NOP_INSTR_ENC),
    parameter int              CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    pipe_stage_skid_if.slave  up,
    pipe_stage_skid_if.master dn,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);
    localparam int PW = 3 * XLEN + DATA_W + CTRL_W;
    localparam logic [PW-1:0] PL_RST = {XLEN'(0), XLEN'(0), NOP_INSTR, DATA_W'(0), CTRL_W'(0)};

    logic          main_valid_q, main_valid_d;
    logic          skid_valid_q, skid_valid_d;
    logic [PW-1:0] main_pl_q, main_pl_d;
    logic [PW-1:0] skid_pl_q, skid_pl_d;
    logic [PW-1:0] in_pl;
    logic          in_fire, out_fire;
    logic [XLEN-1:0]   main_instr;
    logic [CTRL_W-1:0] main_ctrl;

    assign in_pl    = {up.pc, up.pc_nxt, up.instr, up.data, up.ctrl};
    // in_ready comes straight from the skid flag so out_ready never reaches it combinationally
    assign up.ready = ~skid_valid_q;
    assign in_fire  = up.valid & ~skid_valid_q;
    assign out_fire = main_valid_q & dn.ready;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_pl_d    = main_pl_q;
        skid_pl_d    = skid_pl_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || out_fire) begin
            if (skid_valid_q) begin
                main_pl_d    = skid_pl_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                main_pl_d    = in_pl;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_pl_d    = in_pl;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_pl_q    <= PL_RST;
            skid_pl_q    <= PL_RST;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_pl_q    <= main_pl_d;
            skid_pl_q    <= skid_pl_d;
        end
    end

    assign {dn.pc, dn.pc_nxt, main_instr, dn.data, main_ctrl} = main_pl_q;
    assign dn.valid = main_valid_q;
    // Empty stage shows a harmless NOP to decoders that ignore valid
    assign dn.instr = main_valid_q ? main_instr : NOP_INSTR;
    assign dn.ctrl  = main_valid_q ? main_ctrl : '0;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (main_valid_q & ~dn.ready),
        .cnt (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush & (main_valid_q | skid_valid_q)),
        .cnt (flush_cnt)
    );
endmodule
